fft_output_streamer: RTL and testbench
======================================

# fft_output_streamer

Drains one completed 16-point FFT frame from the flattened stage-2 result buses (`yr_stage2_flat`/`yi_stage2_flat`) and streams it out one bin per beat over a valid/ready handshake. It is the read side of the FFT core, the counterpart of the addressed-write input buffer. Each bin is arithmetically right-shifted and saturated to a narrow output width. It sits between the FFT pipeline's stage-2 outputs and any downstream consumer: DMA, magnitude unit or UART bridge.

## Interface
- `N`, 16, number of bins per frame (fixed at 16; index width 4)
- `OUTW2`, 48, width of each signed bin on the input buses
- `OUTW`, 16, width of each signed streamed bin
- `SHIFT`, 0, arithmetic right shift applied before saturation (0..OUTW2-OUTW)

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous reset, active-low
- `yr_stage2_flat`  in  N*OUTW2  real parts; bin k at `[k*OUTW2 +: OUTW2]`
- `yi_stage2_flat`  in  N*OUTW2  imaginary parts, same packing
- `frame_valid`  in  1  flat buses hold a complete frame
- `frame_ready`  out  1  block can accept a frame
- `out_valid`  out  1  `out_re`/`out_im`/`out_idx` are valid
- `out_ready`  in  1  consumer accepts the current beat
- `out_re`  out  OUTW  shifted, saturated real part
- `out_im`  out  OUTW  shifted, saturated imaginary part
- `out_idx`  out  4  frequency bin number of the current beat
- `out_last`  out  1  high with the beat where `out_idx`=15
- `sat_flag`  out  1  sticky per frame: some component saturated
- `frame_drop`  out  1  one-cycle pulse: `frame_valid` was seen while busy

## Operation
- **Reset** (`rst`=0 at an edge): state=IDLE, counter=0.
  - Reset values: `frame_ready`=1, `out_valid`=0, `out_re`=0, `out_im`=0, `out_idx`=0, `out_last`=0, `sat_flag`=0, `frame_drop`=0.
  - Reset mid-stream abandons the frame; no further beats are issued.
- **IDLE**:
  - `frame_ready`=1.
  - On `frame_valid`=1, copy all 2*N bins into an internal register array, clear `sat_flag`, set counter=0, and go to STREAM.
- **STREAM**:
  - `frame_ready`=0.
  - The beat holds bin `sel(counter)`, where `sel` is identity unless bit-reversal is configured.
  - On `out_valid && out_ready`, counter increments.
  - On the handshake where counter=15, the next state is IDLE.
- **Arithmetic**, per component: `t = y >>> SHIFT` (sign-preserving).
  - If `t > 2^(OUTW-1)-1`, output `2^(OUTW-1)-1`.
  - If `t < -2^(OUTW-1)`, output `-2^(OUTW-1)`.
  - Otherwise output `t[OUTW-1:0]`.
  - Any clamp sets `sat_flag` when that beat is presented. `sat_flag` holds until the next frame is accepted.
- **Busy frame**: `frame_valid`=1 in STREAM is ignored and pulses `frame_drop` for one cycle per such cycle. The captured array is unaffected.
- **Source buses** may change freely after the capture edge.

## Timing
- Frame accepted at edge T (IDLE, `frame_valid`=1). At T+1: `out_valid`=1, `out_idx`=0, data for bin 0. Latency is 1 cycle.
- Outputs are registered. While `out_valid && !out_ready`, `out_re`, `out_im`, `out_idx` and `out_last` are held stable.
- With `out_ready` held high, one beat is issued per cycle: 16 beats occupy T+1..T+16.
- Last handshake at edge L:
  - At L+1, `out_valid`=0 and `frame_ready`=1.
  - A new frame can be accepted at edge L+1, giving its first beat at L+2. Minimum frame period is 17 cycles.
- `out_valid` never deasserts without a handshake, except on reset.
- `out_ready` high while `out_valid`=0 has no effect.

## Configuration
- **`FFT_OUT_BITREV_EN`**:
  - **Defined**: beat k reads array position `bitrev4(k)`, e.g. beat 1 reads position 8 and beat 3 reads position 12. Used when the core leaves bins in bit-reversed order. `out_idx` still reports k, the natural frequency index.
  - **Undefined**: beat k reads position k.

## Test plan
- **Reset/idle**: hold `rst`=0 for 3 cycles, then release.
  - Required: all outputs at their reset values and `frame_ready`=1.
- **Natural streaming**: load bin k with re=k*100, im=-k, `SHIFT`=0, `out_ready`=1, macro off.
  - Required: 16 consecutive beats, re 0,100,…,1500, im 0,-1,…,-15.
  - Required: `out_last` only on idx 15, `sat_flag`=0, `frame_ready`=1 on the cycle after.
- **Backpressure**: same frame, `out_ready` toggles 1,0,0,1,…
  - Required: no beat lost or duplicated.
  - Required: data stable during stalls; idx sequence 0..15 exactly.
- **Saturation**: bin 2 re=40000, bin 5 im=-70000, `SHIFT`=0.
  - Required: beat 2 re=32767 and beat 5 im=-32768.
  - Required: `sat_flag` rises at beat 2 and stays 1 through the frame.
  - Required: the next frame with small values clears it on accept.
- **Busy/drop and reset mid-stream**:
  - Pulse `frame_valid` during beat 4. Required: one `frame_drop` pulse and the stream continues unchanged.
  - Assert `rst`=0 at beat 7. Required: `out_valid`=0 next cycle and `frame_ready`=1 after release.
- **Bit-reverse (macro defined)**: bin p re=p.
  - Required: streamed re 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with `out_idx` 0..15.

Source files
------------

// File: rtl/fft_output_streamer.sv
// fft_output_streamer: captures one 16-bin FFT frame from the stage-2 flat
// buses and streams it out one bin per beat over valid/ready. Each component
// is arithmetically shifted right by SHIFT and saturated to OUTW bits.
// Optional feature macro: FFT_OUT_BITREV_EN (beat k reads position bitrev4(k)).
module fft_output_streamer #(
    parameter int unsigned N     = 16,
    parameter int unsigned OUTW2 = 48,
    parameter int unsigned OUTW  = 16,
    parameter int unsigned SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*OUTW2-1:0]   yr_stage2_flat,
    input  logic [N*OUTW2-1:0]   yi_stage2_flat,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUTW-1:0]      out_re,
    output logic [OUTW-1:0]      out_im,
    output logic [3:0]           out_idx,
    output logic                 out_last,
    output logic                 sat_flag,
    output logic                 frame_drop
);

    localparam int unsigned IDXW = 4;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
    localparam logic signed [OUTW2-1:0] SAT_MAX = OUTW2'((64'(1) << (OUTW - 1)) - 64'(1));
    localparam logic signed [OUTW2-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                   state_q, state_d;
    logic [IDXW-1:0]          cnt_d;
    logic                     capture;
    logic                     load;
    logic signed [OUTW2-1:0]  src_re, src_im;
    logic [OUTW:0]            re_s, im_s;
    logic                     valid_d, last_d, ready_d, sat_d, drop_d;
    logic [OUTW-1:0]          re_d, im_d;

    logic signed [OUTW2-1:0]  re_mem [N];
    logic signed [OUTW2-1:0]  im_mem [N];

    // Array position read for beat k.
    function automatic logic [IDXW-1:0] sel(input logic [IDXW-1:0] k);
`ifdef FFT_OUT_BITREV_EN
        return {k[0], k[1], k[2], k[3]};
`else
        return k;
`endif
    endfunction

    // Shift then saturate; MSB of the result flags a clamp.
    function automatic logic [OUTW:0] sat_shift(input logic signed [OUTW2-1:0] y);
        logic signed [OUTW2-1:0] t;
        t = y >>> SHIFT;
        if (t > SAT_MAX)      return {1'b1, SAT_MAX[OUTW-1:0]};
        else if (t < SAT_MIN) return {1'b1, SAT_MIN[OUTW-1:0]};
        else                  return {1'b0, t[OUTW-1:0]};
    endfunction

    // Frame capture: the whole frame is latched on the accept edge.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < int'(N); k++) begin
                re_mem[k] <= yr_stage2_flat[k*OUTW2 +: OUTW2];
                im_mem[k] <= yi_stage2_flat[k*OUTW2 +: OUTW2];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = out_idx;
        valid_d = out_valid;
        capture = 1'b0;
        load    = 1'b0;
        drop_d  = 1'b0;
        sat_d   = sat_flag;
        src_re  = re_mem[sel(IDXW'(out_idx + 4'd1))];
        src_im  = im_mem[sel(IDXW'(out_idx + 4'd1))];

        case (state_q)
            IDLE: begin
                if (frame_valid) begin
                    capture = 1'b1;
                    load    = 1'b1;
                    state_d = STREAM;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    sat_d   = 1'b0;
                    // Bin 0 comes straight off the bus since the array is loading now.
                    src_re  = yr_stage2_flat[sel(IDXW'(0))*OUTW2 +: OUTW2];
                    src_im  = yi_stage2_flat[sel(IDXW'(0))*OUTW2 +: OUTW2];
                end
            end
            STREAM: begin
                drop_d = frame_valid;
                if (out_valid && out_ready) begin
                    if (out_idx == LAST_IDX) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        load  = 1'b1;
                        cnt_d = IDXW'(out_idx + 4'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        re_s    = sat_shift(src_re);
        im_s    = sat_shift(src_im);
        re_d    = load ? re_s[OUTW-1:0] : out_re;
        im_d    = load ? im_s[OUTW-1:0] : out_im;
        sat_d   = sat_d | (load & (re_s[OUTW] | im_s[OUTW]));
        last_d  = valid_d && (cnt_d == LAST_IDX);
        ready_d = (state_d == IDLE);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            out_idx     <= '0;
            frame_ready <= 1'b1;
            out_valid   <= 1'b0;
            out_re      <= '0;
            out_im      <= '0;
            out_last    <= 1'b0;
            sat_flag    <= 1'b0;
            frame_drop  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_idx     <= cnt_d;
            frame_ready <= ready_d;
            out_valid   <= valid_d;
            out_re      <= re_d;
            out_im      <= im_d;
            out_last    <= last_d;
            sat_flag    <= sat_d;
            frame_drop  <= drop_d;
        end
    end

endmodule

// File: tb/tb_fft_output_streamer.sv
// Randomized bench for fft_output_streamer against a frame-level reference
// model (bin order, shift/clamp arithmetic, sticky saturation per frame).
module tb_fft_output_streamer;

    localparam int unsigned N     = 16;
    localparam int unsigned OUTW2 = 48;
    localparam int unsigned OUTW  = 16;
    localparam int unsigned SHIFT = 0;
    localparam longint SMAX = (longint'(1) <<< (OUTW - 1)) - 1;
    localparam longint SMIN = -SMAX - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [N*OUTW2-1:0]  yr_flat, yi_flat;
    logic                frame_valid, frame_ready;
    logic                out_valid, out_ready;
    logic [OUTW-1:0]     out_re, out_im;
    logic [3:0]          out_idx;
    logic                out_last, sat_flag, frame_drop;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint re_in [N];
    longint im_in [N];

    fft_output_streamer #(.N(N), .OUTW2(OUTW2), .OUTW(OUTW), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst),
        .yr_stage2_flat(yr_flat), .yi_stage2_flat(yi_flat),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
        .out_last(out_last), .sat_flag(sat_flag), .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference arithmetic: divide by 2^SHIFT rounding toward -inf, then clamp.
    function automatic longint ref_scaled(input longint v);
        return v >>> SHIFT;
    endfunction

    function automatic longint ref_val(input longint v);
        longint t = ref_scaled(v);
        if (t > SMAX) return SMAX;
        if (t < SMIN) return SMIN;
        return t;
    endfunction

    function automatic bit ref_hit(input longint v);
        longint t = ref_scaled(v);
        return (t > SMAX) || (t < SMIN);
    endfunction

    // Which stored bin is delivered on beat k.
    function automatic int beat_pos(input int k);
`ifdef FFT_OUT_BITREV_EN
        int r = 0;
        for (int b = 0; b < 4; b++)
            if (((k >> b) & 1) == 1) r = r + (8 >> b);
        return r;
`else
        return k;
`endif
    endfunction

    task automatic drive_bus();
        for (int k = 0; k < int'(N); k++) begin
            yr_flat[k*OUTW2 +: OUTW2] = OUTW2'(re_in[k]);
            yi_flat[k*OUTW2 +: OUTW2] = OUTW2'(im_in[k]);
        end
    endtask

    task automatic scramble_bus();
        for (int k = 0; k < int'(N); k++) begin
            yr_flat[k*OUTW2 +: OUTW2] = OUTW2'({$urandom, $urandom});
            yi_flat[k*OUTW2 +: OUTW2] = OUTW2'({$urandom, $urandom});
        end
    endtask

    function automatic longint rand_val();
        logic [OUTW2-1:0] big;
        big = OUTW2'({$urandom, $urandom});
        if ($urandom_range(0, 3) == 0) return longint'($signed(big));
        return longint'($urandom_range(0, 60000)) - 30000;
    endfunction

    // mode 0: ready always; 1: pattern 1,0,0; 2: random.
    task automatic run_frame(input string name, input int mode, input int drop_at, input int rst_at);
        int  n, cyc, guard;
        bit  sat_e, drop_e, dropped, rdy;
        int  p;
        drive_bus();
        guard = 0;
        while (!frame_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_value({name, "/frame_ready_pre"}, longint'(frame_ready), 1);
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        scramble_bus();
        n = 0; cyc = 0; sat_e = 0; drop_e = 0; dropped = 0;
        while (n < int'(N) && cyc < 200) begin
            p = beat_pos(n);
            sat_e = sat_e | ref_hit(re_in[p]) | ref_hit(im_in[p]);
            check_value({name, "/valid"}, longint'(out_valid), 1);
            check_value({name, "/re"}, longint'($signed(out_re)), ref_val(re_in[p]));
            check_value({name, "/im"}, longint'($signed(out_im)), ref_val(im_in[p]));
            check_value({name, "/idx"}, longint'(out_idx), longint'(n));
            check_value({name, "/last"}, longint'(out_last), longint'(n == int'(N) - 1));
            check_value({name, "/sat"}, longint'(sat_flag), longint'(sat_e));
            check_value({name, "/frame_ready"}, longint'(frame_ready), 0);
            check_value({name, "/drop"}, longint'(frame_drop), longint'(drop_e));
            drop_e = 0;
            if (n == rst_at) begin
                rst = 1'b0;
                out_ready = 1'b0;
                @(negedge clk);
                check_value({name, "/rst_valid"}, longint'(out_valid), 0);
                rst = 1'b1;
                @(negedge clk);
                check_value({name, "/rst_ready"}, longint'(frame_ready), 1);
                check_value({name, "/rst_valid2"}, longint'(out_valid), 0);
                check_value({name, "/rst_sat"}, longint'(sat_flag), 0);
                return;
            end
            if (n == drop_at && !dropped) begin
                frame_valid = 1'b1;
                dropped = 1;
                drop_e = 1;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            cyc++;
            @(negedge clk);
            frame_valid = 1'b0;
            if (rdy) n++;
        end
        check_value({name, "/beats"}, longint'(n), longint'(N));
        check_value({name, "/end_valid"}, longint'(out_valid), 0);
        check_value({name, "/end_ready"}, longint'(frame_ready), 1);
        check_value({name, "/end_last"}, longint'(out_last), 0);
        check_value({name, "/end_sat"}, longint'(sat_flag), longint'(sat_e));
        check_value({name, "/end_drop"}, longint'(frame_drop), longint'(drop_e));
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        frame_valid = 1'b0;
        out_ready = 1'b0;
        yr_flat = '0;
        yi_flat = '0;
        repeat (3) @(negedge clk);
        check_value("reset/frame_ready", longint'(frame_ready), 1);
        check_value("reset/valid", longint'(out_valid), 0);
        check_value("reset/re", longint'(out_re), 0);
        check_value("reset/im", longint'(out_im), 0);
        check_value("reset/idx", longint'(out_idx), 0);
        check_value("reset/last", longint'(out_last), 0);
        check_value("reset/sat", longint'(sat_flag), 0);
        check_value("reset/drop", longint'(frame_drop), 0);
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_value("idle/ready_no_effect", longint'(out_valid), 0);
        check_value("idle/frame_ready", longint'(frame_ready), 1);
        out_ready = 1'b0;

        for (int k = 0; k < int'(N); k++) begin re_in[k] = k * 100; im_in[k] = -k; end
        run_frame("natural", 0, -1, -1);
        run_frame("backpressure", 1, -1, -1);

        for (int k = 0; k < int'(N); k++) begin re_in[k] = k; im_in[k] = k; end
        re_in[2] = 40000;
        im_in[5] = -70000;
        run_frame("saturate", 0, -1, -1);

        for (int k = 0; k < int'(N); k++) begin re_in[k] = -k * 7; im_in[k] = k * 3; end
        run_frame("sat_clear", 2, -1, -1);

        run_frame("drop", 2, 4, -1);
        run_frame("midreset", 2, -1, 7);

        for (int k = 0; k < int'(N); k++) begin re_in[k] = k; im_in[k] = 0; end
        run_frame("order", 0, -1, -1);

        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < int'(N); k++) begin re_in[k] = rand_val(); im_in[k] = rand_val(); end
            run_frame($sformatf("random%0d", f), 2, int'($urandom_range(0, 20)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
